ovl_cycle_sequence_sched: RTL and testbench

- Multi-channel cycle-sequence checking engine with a shared violation-report port.
- Tracks NUM_CH independent event sequences, each NUM_CKS steps long, using the OVL cycle-sequence queue semantics.
- Counts completed sequences per channel and latches violations as pending.
- A round-robin scheduler serialises pending violations onto one valid/ready report interface feeding the testbench or error-log collector.

---
 rtl/ovl_seq_pkg.sv | 29 ++
 rtl/ovl_cycle_sequence_sched_if.sv | 13 +
 rtl/ovl_seq_track.sv | 73 +++++++
 rtl/ovl_cycle_sequence_sched.sv | 77 +++++++
 tb/tb_ovl_cycle_sequence_sched.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ovl_seq_pkg.sv
// Shared definitions for the cycle-sequence checker: checking-mode encodings
// and the round-robin winner search used by the report scheduler.
package ovl_seq_pkg;

  localparam int SEQ_MOST_PIPE    = 0;
  localparam int SEQ_FIRST_PIPE   = 1;
  localparam int SEQ_FIRST_NOPIPE = 2;

  // First set bit of req at or after ptr, wrapping at n; returns 0 when req is empty.
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k < n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ovl_cycle_sequence_sched_if.sv
// Violation-report channel: valid/ready handshake carrying channel id and match count.
interface ovl_cycle_sequence_sched_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CH_W-1:0]  rpt_ch;
  logic [CNT_W-1:0] rpt_cnt;

  modport master (output rpt_valid, output rpt_ch, output rpt_cnt, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_ch, input rpt_cnt, output rpt_ready);
endinterface

// File: rtl/ovl_seq_track.sv
// One sequence channel: OVL cycle-sequence queue, violation/match detection,
// saturating match counter, pending flag with count snapshot, sticky overflow.
module ovl_seq_track
  import ovl_seq_pkg::*;
#(
  parameter int NUM_CKS        = 3,
  parameter int NECESSARY_COND = 0,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CKS-1:0] i_ev,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic               i_grant,
  output logic               o_pend,
  output logic [CNT_W-1:0]   o_snap,
  output logic               o_ovf
);

  // Queue bit 0 is only ever consumed as the match term, so it is not stored.
  logic [NUM_CKS-1:1] r_q;
  logic [NUM_CKS-1:1] w_q_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_snap;
  logic               r_pend;
  logic               r_ovf;
  logic               w_viol;
  logic               w_match;

  always_comb begin
    w_q_nxt = '0;
    if (NECESSARY_COND == SEQ_FIRST_NOPIPE)
      w_q_nxt[NUM_CKS-1] = i_ev[NUM_CKS-1] & ~|r_q;
    else
      w_q_nxt[NUM_CKS-1] = i_ev[NUM_CKS-1];
    for (int i = 1; i < NUM_CKS - 1; i++)
      w_q_nxt[i] = r_q[i+1] & i_ev[i];
    if (!i_en) w_q_nxt = '0;
  end

  always_comb begin
    if (NECESSARY_COND == SEQ_MOST_PIPE)
      w_viol = i_en & r_q[1] & ~i_ev[0];
    else
      w_viol = i_en & |(r_q & ~i_ev[NUM_CKS-2:0]);
    w_match = i_en & r_q[1] & i_ev[0];
  end

  // A grant in the same cycle as a new violation behaves like a fresh pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_snap <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q <= w_q_nxt;
      if (i_clr)                          r_cnt <= '0;
      else if (w_match && r_cnt != '1)    r_cnt <= r_cnt + CNT_W'(1);
      if (i_clr)                          r_ovf <= 1'b0;
      else if (w_viol && r_pend && !i_grant) r_ovf <= 1'b1;
      if (w_viol && (!r_pend || i_grant)) r_snap <= r_cnt;
      r_pend <= (r_pend & ~i_grant) | w_viol;
    end
  end

  assign o_pend = r_pend;
  assign o_snap = r_snap;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/ovl_cycle_sequence_sched.sv
// Multi-channel cycle-sequence checker; pending violations are serialised
// round-robin onto a single valid/ready report port.
module ovl_cycle_sequence_sched
  import ovl_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int NUM_CKS        = 3,
  parameter int NECESSARY_COND = 0,
  parameter int CNT_W          = 8,
  parameter int CH_W           = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*NUM_CKS-1:0] event_sequence,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         clr,
  output logic [NUM_CH-1:0]         ovf,
  output logic                      busy,
  ovl_cycle_sequence_sched_if.master rpt
);

  if (NUM_CKS < 2) begin : g_bad_cks
    $error("ovl_cycle_sequence_sched: NUM_CKS must be >= 2");
  end

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_grant;
  logic [CNT_W-1:0]  w_snap [NUM_CH];
  logic [CH_W-1:0]   w_win_idx;
  logic [CH_W-1:0]   r_ptr;
  logic              w_load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ovl_seq_track #(
      .NUM_CKS       (NUM_CKS),
      .NECESSARY_COND(NECESSARY_COND),
      .CNT_W         (CNT_W)
    ) u_trk (
      .clk    (clk),
      .reset  (reset),
      .i_ev   (event_sequence[c*NUM_CKS +: NUM_CKS]),
      .i_en   (ch_en[c]),
      .i_clr  (clr[c]),
      .i_grant(w_grant[c]),
      .o_pend (w_pend[c]),
      .o_snap (w_snap[c]),
      .o_ovf  (ovf[c])
    );
  end

  always_comb begin
    w_load    = (~rpt.rpt_valid | rpt.rpt_ready) & (|w_pend);
    w_win_idx = CH_W'(rr_pick(32'(w_pend), int'(r_ptr), NUM_CH));
    w_grant   = '0;
    if (w_load) w_grant[w_win_idx] = 1'b1;
  end

  // Report register: refills on the transfer edge so back-to-back reports need no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_ch    <= '0;
      rpt.rpt_cnt   <= '0;
      r_ptr         <= '0;
    end else if (w_load) begin
      rpt.rpt_valid <= 1'b1;
      rpt.rpt_ch    <= w_win_idx;
      rpt.rpt_cnt   <= w_snap[w_win_idx];
      r_ptr         <= (w_win_idx == CH_W'(NUM_CH - 1)) ? '0 : w_win_idx + CH_W'(1);
    end else if (rpt.rpt_ready) begin
      rpt.rpt_valid <= 1'b0;
    end
  end

  assign busy = (|w_pend) | rpt.rpt_valid;

endmodule

// File: tb/tb_ovl_cycle_sequence_sched.sv
// Bench for ovl_cycle_sequence_sched: a mode-0 and a mode-2 instance share stimulus;
// a sequence-level reference model feeds per-instance report scoreboards.
module tb_ovl_cycle_sequence_sched;
  localparam int NCH = 4;
  localparam int NK  = 3;
  localparam int CW  = 8;
  localparam int MODES [2] = '{0, 2};

  logic            clk;
  logic            reset;
  logic [NCH*NK-1:0] ev;
  logic [NCH-1:0]  en;
  logic [NCH-1:0]  clr;
  logic            rready;
  logic [NCH-1:0]  ovf0, ovf1;
  logic            busy0, busy1;

  ovl_cycle_sequence_sched_if #(.CH_W(2), .CNT_W(CW)) if0 ();
  ovl_cycle_sequence_sched_if #(.CH_W(2), .CNT_W(CW)) if1 ();
  assign if0.rpt_ready = rready;
  assign if1.rpt_ready = rready;

  ovl_cycle_sequence_sched #(.NUM_CH(NCH), .NUM_CKS(NK), .NECESSARY_COND(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .event_sequence(ev), .ch_en(en), .clr(clr),
    .ovf(ovf0), .busy(busy0), .rpt(if0));
  ovl_cycle_sequence_sched #(.NUM_CH(NCH), .NUM_CKS(NK), .NECESSARY_COND(2), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .event_sequence(ev), .ch_en(en), .clr(clr),
    .ovf(ovf1), .busy(busy1), .rpt(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each in-flight sequence is tracked by its age: age a expects step bit NK-1-a.
  typedef struct { int m; int ch; int age; } seq_t;
  typedef struct { int ch; int cnt; } rpt_t;
  seq_t live[$];
  rpt_t expq0[$];
  rpt_t expq1[$];
  int   m_cnt  [2][NCH];
  int   m_snap [2][NCH];
  bit   m_pend [2][NCH];
  bit   m_ovf  [2][NCH];
  int   m_ptr  [2];
  bit   m_rvalid [2];

  task automatic model_step();
    bit viol [2][NCH];
    bit match[2][NCH];
    bit had  [2][NCH];
    bit grant[2][NCH];
    seq_t nl[$];
    seq_t s;
    rpt_t r;
    int w, c;
    bit anyp;
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NCH; k++) begin
        viol[m][k] = 0; match[m][k] = 0; had[m][k] = 0; grant[m][k] = 0;
      end
    if (reset) begin
      live.delete(); expq0.delete(); expq1.delete();
      for (int m = 0; m < 2; m++) begin
        m_ptr[m] = 0; m_rvalid[m] = 0;
        for (int k = 0; k < NCH; k++) begin
          m_cnt[m][k] = 0; m_snap[m][k] = 0; m_pend[m][k] = 0; m_ovf[m][k] = 0;
        end
      end
      return;
    end
    foreach (live[i]) begin
      s = live[i];
      had[s.m][s.ch] = 1;
      if (en[s.ch]) begin
        if (ev[s.ch*NK + NK-1-s.age]) begin
          if (s.age == NK-1) match[s.m][s.ch] = 1;
          else begin s.age++; nl.push_back(s); end
        end else if (MODES[s.m] != 0 || s.age == NK-1) begin
          viol[s.m][s.ch] = 1;
        end
      end
    end
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NCH; k++)
        if (en[k] && ev[k*NK + NK-1] && (MODES[m] != 2 || !had[m][k])) begin
          s.m = m; s.ch = k; s.age = 1; nl.push_back(s);
        end
    live = nl;
    for (int m = 0; m < 2; m++) begin
      anyp = 0; w = 0;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr[m] + k) % NCH;
        if (!anyp && m_pend[m][c]) begin anyp = 1; w = c; end
      end
      if (anyp && (!m_rvalid[m] || rready)) begin
        grant[m][w] = 1; m_rvalid[m] = 1;
        r.ch = w; r.cnt = m_snap[m][w];
        if (m == 0) expq0.push_back(r); else expq1.push_back(r);
        m_ptr[m] = (w + 1) % NCH;
      end else if (m_rvalid[m] && rready) begin
        m_rvalid[m] = 0;
      end
      for (int k = 0; k < NCH; k++) begin
        if (clr[k]) m_ovf[m][k] = 0;
        else if (viol[m][k] && m_pend[m][k] && !grant[m][k]) m_ovf[m][k] = 1;
        if (viol[m][k] && (!m_pend[m][k] || grant[m][k])) m_snap[m][k] = m_cnt[m][k];
        m_pend[m][k] = (m_pend[m][k] && !grant[m][k]) || viol[m][k];
        if (clr[k]) m_cnt[m][k] = 0;
        else if (match[m][k] && m_cnt[m][k] < 255) m_cnt[m][k]++;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int m, input bit v, input int ch, input int cnt,
                     input logic [NCH-1:0] o, input bit b);
    rpt_t f;
    int qs;
    bit anyp;
    int eovf;
    qs = (m == 0) ? expq0.size() : expq1.size();
    chk($sformatf("rpt_valid[m%0d]", m), int'(v), int'(qs > 0));
    if (v && qs > 0) begin
      f = (m == 0) ? expq0[0] : expq1[0];
      chk($sformatf("rpt_ch[m%0d]", m), ch, f.ch);
      chk($sformatf("rpt_cnt[m%0d]", m), cnt, f.cnt);
      if (rready) begin
        if (m == 0) void'(expq0.pop_front()); else void'(expq1.pop_front());
      end
    end
    anyp = 0; eovf = 0;
    for (int k = 0; k < NCH; k++) begin
      anyp |= m_pend[m][k];
      if (m_ovf[m][k]) eovf |= (1 << k);
    end
    chk($sformatf("ovf[m%0d]", m), int'(o), eovf);
    chk($sformatf("busy[m%0d]", m), int'(b), int'(anyp || m_rvalid[m]));
  endtask

  always @(negedge clk) begin
    mon(0, if0.rpt_valid, int'(if0.rpt_ch), int'(if0.rpt_cnt), ovf0, busy0);
    mon(1, if1.rpt_valid, int'(if1.rpt_ch), int'(if1.rpt_cnt), ovf1, busy1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [NCH*NK-1:0] evv(input logic [2:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_valid0(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (if0.rpt_valid) ok = 1;
    end
    if (!ok) chk("wait_rpt_valid_timeout", 0, 1);
  endtask

  bit ok;
  int order [3] = '{2, 3, 1};

  initial begin
    reset = 1'b1; ev = '0; en = '1; clr = '0; rready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_valid", int'(if0.rpt_valid), 0);
    chk("reset_busy", int'(busy0), 0);
    reset = 1'b0;

    // complete sequence: no report
    ev = evv(3'b100, 0, 0, 0); tick();
    ev = evv(3'b010, 0, 0, 0); tick();
    ev = evv(3'b001, 0, 0, 0); tick();
    ev = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("match_no_rpt", int'(if0.rpt_valid), 0);
    end

    // missed last step, held stall
    do_reset();
    rready = 1'b0;
    ev = evv(3'b100, 0, 0, 0); tick();
    ev = evv(3'b010, 0, 0, 0); tick();
    ev = '0; tick();
    tick(); @(negedge clk);
    chk("viol_latency_valid", int'(if0.rpt_valid), 1);
    chk("viol_ch", int'(if0.rpt_ch), 0);
    chk("viol_cnt", int'(if0.rpt_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      chk("stall_valid", int'(if0.rpt_valid), 1);
      chk("stall_cnt", int'(if0.rpt_cnt), 0);
    end
    rready = 1'b1; tick(); tick();

    // round-robin from ptr=2
    do_reset();
    ev = evv(0, 3'b100, 0, 0); tick();
    ev = evv(0, 3'b010, 0, 0); tick();
    ev = '0; tick(); tick(); tick(); tick();
    ev = evv(0, 3'b100, 3'b100, 3'b100); tick();
    ev = evv(0, 3'b010, 3'b010, 3'b010); tick();
    ev = '0;
    wait_valid0(10, ok);
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        chk("rr_order", int'(if0.rpt_ch), order[k]);
        @(negedge clk);
      end
      chk("rr_busy_drop", int'(busy0), 0);
    end

    // mode 2 ignores a restart while a sequence is in flight
    do_reset();
    ev = evv(3'b100, 0, 0, 0); tick();
    ev = evv(3'b110, 0, 0, 0); tick();
    ev = evv(3'b001, 0, 0, 0); tick();
    ev = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("nopipe_no_viol", int'(if1.rpt_valid), 0);
    end
    ev = evv(3'b100, 0, 0, 0); tick();
    ev = evv(3'b010, 0, 0, 0); tick();
    ev = '0; tick(); tick(); @(negedge clk);
    chk("nopipe_cnt", int'(if1.rpt_cnt), 1);
    chk("nopipe_valid", int'(if1.rpt_valid), 1);
    tick(); tick();

    // overflow while the report register is occupied
    do_reset();
    rready = 1'b0;
    ev = evv(0, 3'b100, 0, 0); tick();
    ev = evv(0, 3'b010, 0, 0); tick();
    ev = '0; tick();
    for (int r = 0; r < 2; r++) begin
      ev = evv(3'b100, 0, 0, 0); tick();
      ev = evv(3'b010, 0, 0, 0); tick();
      ev = '0; tick();
    end
    tick(); @(negedge clk);
    chk("ovf_set", int'(ovf0[0]), 1);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    clr = 4'b0001; tick(); clr = '0;
    @(negedge clk);
    chk("ovf_clr", int'(ovf0[0]), 0);

    // counter saturation, then reset during a report
    do_reset();
    ev = evv(3'b111, 0, 0, 0);
    for (int i = 0; i < 262; i++) tick();
    rready = 1'b0;
    ev = '0;
    wait_valid0(10, ok);
    if (ok) chk("sat_cnt", int'(if0.rpt_cnt), 255);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_valid", int'(if0.rpt_valid), 0);
    rready = 1'b1;
    ev = evv(3'b100, 0, 0, 0); tick();
    ev = evv(3'b010, 0, 0, 0); tick();
    ev = '0;
    wait_valid0(10, ok);
    if (ok) chk("post_reset_cnt", int'(if0.rpt_cnt), 0);
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NCH*NK; b++) ev[b] = ($urandom_range(0, 99) < 60);
      for (int k = 0; k < NCH; k++) begin
        en[k]  = ($urandom_range(0, 99) < 95);
        clr[k] = ($urandom_range(0, 99) < 2);
      end
      rready = ($urandom_range(0, 99) < 65);
      reset  = ($urandom_range(0, 999) < 3);
      tick();
    end
    reset = 1'b0; ev = '0; en = '1; clr = '0; rready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("drain_busy0", int'(busy0), 0);
    chk("drain_busy1", int'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
